// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx
// Brief    : Drains bytes from a synchronous FIFO and shifts each one out as a
//            UART frame (start, WIDTH data bits LSB first, stop).
//            Define UART_TX_PARITY_EN to insert an even-parity bit before stop.
// Revision : 1.0  initial release
// ============================================================================
module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tx_en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd_en,
    output logic             tx,
    output logic             busy,
    output logic             tx_done
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int c_IDX_W = $clog2(WIDTH) + 1;

    localparam logic [c_CNT_W-1:0] c_BIT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_DONE_AT  = c_CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_POP    = 3'd1,
        S_LATCH  = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd5,
`endif
        S_STOP   = 3'd6
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_IDX_W-1:0] r_bit_idx;
    logic [WIDTH-1:0]   r_shift;
`ifdef UART_TX_PARITY_EN
    logic               r_parity;
`endif

    logic               w_bit_end;
    logic [WIDTH-1:0]   w_shift_next;

    assign w_bit_end    = (r_cnt == c_BIT_LAST);
    assign w_shift_next = {1'b0, r_shift[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
            tx         <= 1'b1;
            fifo_rd_en <= 1'b0;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            fifo_rd_en <= 1'b0;
            tx_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (tx_en && !fifo_empty) begin
                        r_state    <= S_POP;
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                // FIFO read data is registered, so it is only valid in LATCH.
                S_POP: begin
                    r_state <= S_LATCH;
                end
                S_LATCH: begin
                    r_shift  <= fifo_dout;
`ifdef UART_TX_PARITY_EN
                    r_parity <= ^fifo_dout;
`endif
                    r_cnt    <= '0;
                    tx       <= 1'b0;
                    r_state  <= S_START;
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        tx        <= r_shift[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit_idx == c_IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                            tx      <= r_parity;
                            r_state <= S_PARITY;
`else
                            tx      <= 1'b1;
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_shift   <= w_shift_next;
                            tx        <= w_shift_next[0];
                            r_bit_idx <= r_bit_idx + c_IDX_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        tx      <= 1'b1;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
`endif
                // tx_done is raised one edge early so it coincides with the
                // final stop-bit cycle, the last cycle busy is high.
                S_STOP: begin
                    if (r_cnt == c_DONE_AT) begin
                        tx_done <= 1'b1;
                    end
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    tx      <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_uart_tx
// Brief    : Directed self-checking bench for fifo_uart_tx with a FIFO model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int c_CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int c_FL  = 11;
`else
    localparam int c_FL  = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_en = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       tx_done;

    logic       push = 1'b0;
    logic [7:0] push_data = 8'h00;
    logic [7:0] q[$];
    int         rd_count = 0;
    int         underflow = 0;
    int         errors = 0;
    int         checks = 0;

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(c_CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_en      (tx_en),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    // Synchronous FIFO model: registered read data and registered empty flag.
    always @(posedge clk) begin
        if (push) q.push_back(push_data);
        if (fifo_rd_en) begin
            rd_count <= rd_count + 1;
            if (q.size() == 0) underflow <= underflow + 1;
            else fifo_dout <= q.pop_front();
        end
        fifo_empty <= (q.size() == 0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        push      = 1'b1;
        push_data = b;
        @(negedge clk);
        push      = 1'b0;
    endtask

    // Waits (bounded) for the start-bit fall, then checks every cycle of the
    // frame: {tx, busy, tx_done}. Returns the number of cycles waited.
    task automatic frame_check(input logic [7:0] b, input string tag,
                               input int drop_at, output int waited);
        logic [c_FL-1:0] bits;
        waited = 0;
        while (tx !== 1'b0 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (tx !== 1'b0) begin
            check({tag, " start_timeout"}, {31'd0, tx}, 32'd0);
            return;
        end
`ifdef UART_TX_PARITY_EN
        bits = {1'b1, ^b, b, 1'b0};
`else
        bits = {1'b1, b, 1'b0};
`endif
        for (int c = 0; c < c_FL * c_CPB; c++) begin
            if (c > 0) @(negedge clk);
            check($sformatf("%s cyc%0d {tx,busy,done}", tag, c),
                  {29'd0, tx, busy, tx_done},
                  {29'd0, bits[c / c_CPB], 1'b1, (c == c_FL * c_CPB - 1)});
            if (c == drop_at) tx_en = 1'b0;
        end
    endtask

    initial begin
        int         w;
        int         base;
        logic [7:0] exp_b [32];

        // Reset state
        repeat (3) @(negedge clk);
        check("reset {tx,busy,done,rd}", {28'd0, tx, busy, tx_done, fifo_rd_en}, 32'h8);
        rst_n = 1'b1;

        // Empty FIFO with tx_en high: nothing happens
        tx_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("empty {tx,busy,rd}", {29'd0, tx, busy, fifo_rd_en}, 32'h4);
        end
        check("empty rd_count", rd_count, 0);

        // Single byte 0x7C: exact pop/latch/fall timing then the full frame
        push_byte(8'h7C);
        @(negedge clk);
        check("7C n+1 {rd,busy,tx}", {29'd0, fifo_rd_en, busy, tx}, 32'h7);
        @(negedge clk);
        check("7C n+2 {rd,busy,tx}", {29'd0, fifo_rd_en, busy, tx}, 32'h3);
        @(negedge clk);
        frame_check(8'h7C, "7C", -1, w);
        check("7C fall at n+3", w, 0);
        @(negedge clk);
        check("7C after {tx,busy,done}", {29'd0, tx, busy, tx_done}, 32'h4);
        check("7C rd_count", rd_count, 1);

        // 32 bytes back to back, FIFO order, 3-clock gap
        tx_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            exp_b[i] = 8'((i * 37 + 5) & 8'hFF);
            push_byte(exp_b[i]);
        end
        @(negedge clk);
        check("burst queued empty", {31'd0, fifo_empty}, 32'd0);
        base  = rd_count;
        tx_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            frame_check(exp_b[i], $sformatf("burst%0d", i), -1, w);
            if (i > 0) check($sformatf("burst%0d gap", i), w, 4);
        end
        repeat (20) @(negedge clk);
        check("burst rd pulses", rd_count - base, 32);
        check("burst end {empty,busy,tx}", {29'd0, fifo_empty, busy, tx}, 32'h5);

        // tx_en dropped mid-DATA of 0xA5 with 0x3C still queued
        tx_en = 1'b0;
        push_byte(8'hA5);
        push_byte(8'h3C);
        base  = rd_count;
        tx_en = 1'b1;
        frame_check(8'hA5, "A5", 12, w);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("held {busy,tx,rd}", {29'd0, busy, tx, fifo_rd_en}, 32'h2);
        end
        check("held rd pulses", rd_count - base, 1);
        check("held queue nonempty", {31'd0, fifo_empty}, 32'd0);
        tx_en = 1'b1;
        frame_check(8'h3C, "3C", -1, w);

        // Asynchronous reset in the middle of a DATA bit
        tx_en = 1'b0;
        @(negedge clk);
        push_byte(8'h96);
        push_byte(8'h5A);
        base  = rd_count;
        tx_en = 1'b1;
        for (int i = 0; i < 50 && tx !== 1'b0; i++) @(negedge clk);
        check("rst frame fall", {31'd0, tx}, 32'd0);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async rst {tx,busy,rd,done}", {28'd0, tx, busy, fifo_rd_en, tx_done}, 32'h8);
        @(negedge clk);
        rst_n = 1'b1;
        frame_check(8'h5A, "5A after rst", -1, w);
        repeat (10) @(negedge clk);
        check("rst rd pulses", rd_count - base, 2);
        check("rst end {empty,busy,tx}", {29'd0, fifo_empty, busy, tx}, 32'h5);
        check("no underflow", underflow, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
